trig_seq_ctrl: RTL

TRIG_SEQ_CTRL -- requirements
Module: trig_seq_ctrl

---
 rtl/trig_seq_pkg.sv | 29 ++
 rtl/sync_edge_det.sv | 36 +++
 rtl/trig_seq_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/trig_seq_pkg.sv
// Shared types and defaults for the trigger sequencer: FSM state encoding,
// default timing/width constants, and the half-period interpretation helper.
package trig_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_HIGH = 3'd2,
        ST_LOW  = 3'd3,
        ST_DONE = 3'd4
    } tsc_state_e;

    localparam int unsigned TSC_HALF_PERIOD_DEF = 1250000;
    localparam int unsigned TSC_CNT_W           = 16;
    localparam logic [31:0] TSC_HP_USE_DEF      = 32'hFFFF_FFFF;

    // 0 would never expire, all-ones selects the built-in default rate.
    function automatic logic [31:0] tsc_eff_half_period(input logic [31:0] hp,
                                                        input logic [31:0] hp_def);
        if (hp == 32'd0) begin
            return 32'd1;
        end else if (hp == TSC_HP_USE_DEF) begin
            return hp_def;
        end else begin
            return hp;
        end
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser with rising-edge detector. Edges are suppressed until
// the pipeline holds only post-reset samples, so a level held through reset
// does not look like a fresh edge.
module sync_edge_det (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o
);

    logic       meta_q;
    logic       sync_q;
    logic       prev_q;
    logic [1:0] fill_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            fill_q <= 2'd0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            if (fill_q != 2'd3) begin
                fill_q <= fill_q + 2'd1;
            end
        end
    end

    assign level_o = sync_q;
    assign rise_o  = (fill_q == 2'd3) && sync_q && !prev_q;

endmodule

// File: rtl/trig_seq_ctrl.sv
// Trigger burst sequencer: on a host start edge emits num_trig square-wave
// periods (or runs until abort) of configurable half-period to the signal generator.
module trig_seq_ctrl
    import trig_seq_pkg::*;
#(
    parameter int unsigned HALF_PERIOD_DEF = TSC_HALF_PERIOD_DEF,
    parameter int unsigned CNT_W           = TSC_CNT_W
) (
    input  logic             clki,
    input  logic             reset_n,
    input  logic [31:0]      cmd,
    input  logic [31:0]      half_period,
    input  logic [CNT_W-1:0] num_trig,
    output logic             trig_to_siggen,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] trig_count
);

    localparam logic [31:0] HP_DEF = 32'(HALF_PERIOD_DEF);

    logic start_lvl;
    logic start_p;
    logic abort_s;
    logic abort_rise;
    logic unused_sigs;

    sync_edge_det u_sync_start (
        .clk_i   (clki),
        .rst_n_i (reset_n),
        .d_i     (cmd[0]),
        .level_o (start_lvl),
        .rise_o  (start_p)
    );

    sync_edge_det u_sync_abort (
        .clk_i   (clki),
        .rst_n_i (reset_n),
        .d_i     (cmd[1]),
        .level_o (abort_s),
        .rise_o  (abort_rise)
    );

    assign unused_sigs = ^{cmd[31:2], start_lvl, abort_rise};

    tsc_state_e       state_q;
    logic             trig_q;
    logic             done_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] ntrig_q;
    logic [31:0]      phase_q;
    logic [31:0]      hp_q;
    logic [31:0]      hp_d;
    logic             phase_end;
    logic             burst_end;

    assign hp_d      = tsc_eff_half_period(half_period, HP_DEF);
    assign phase_end = (phase_q == hp_q - 32'd1);
    assign burst_end = (ntrig_q != '0) && (count_q == ntrig_q);

    always_ff @(posedge clki) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            trig_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
            ntrig_q <= '0;
            phase_q <= 32'd0;
            hp_q    <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_p && !abort_s) begin
                        state_q <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (abort_s) begin
                        state_q <= ST_IDLE;
                        trig_q  <= 1'b0;
                    end else begin
                        hp_q    <= hp_d;
                        ntrig_q <= num_trig;
                        count_q <= '0;
                        phase_q <= 32'd0;
                        done_q  <= 1'b0;
                        trig_q  <= 1'b1;
                        state_q <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (abort_s) begin
                        state_q <= ST_IDLE;
                        trig_q  <= 1'b0;
                    end else if (phase_end) begin
                        state_q <= ST_LOW;
                        trig_q  <= 1'b0;
                        phase_q <= 32'd0;
                        count_q <= count_q + CNT_W'(1);
                    end else begin
                        phase_q <= phase_q + 32'd1;
                    end
                end
                ST_LOW: begin
                    if (abort_s) begin
                        state_q <= ST_IDLE;
                        trig_q  <= 1'b0;
                    end else if (phase_end) begin
                        phase_q <= 32'd0;
                        // count_q already includes the period that just finished
                        if (burst_end) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_HIGH;
                            trig_q  <= 1'b1;
                        end
                    end else begin
                        phase_q <= phase_q + 32'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    trig_q  <= 1'b0;
                end
            endcase
        end
    end

    assign trig_to_siggen = trig_q;
    assign done           = done_q;
    assign trig_count     = count_q;
    assign busy           = (state_q == ST_ARM) || (state_q == ST_HIGH) || (state_q == ST_LOW);

endmodule
